// File: rtl/seven_seg_pkg.sv
// Shared types, constants and helpers for the four-digit scan controller.
package seven_seg_pkg;

  typedef enum logic {
    S_GAP = 1'b0,
    S_ON  = 1'b1
  } scan_state_t;

  localparam int         NDIG    = 4;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  // Pick nibble idx out of a 16-bit display word (idx 0 = least significant digit).
  function automatic logic [3:0] nibble_sel(input logic [15:0] value16, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = value16[3:0];
      2'd1:    nib = value16[7:4];
      2'd2:    nib = value16[11:8];
      default: nib = value16[15:12];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/seven_seg_lz_mask.sv
// Leading-zero blanking mask: a digit is dark when it and every digit above it are zero.
module seven_seg_lz_mask
  import seven_seg_pkg::*;
(
  input  logic [15:0]     shadow,
  input  logic            Blank_lz,
  output logic [NDIG-1:0] blank
);

  // Chain the zero test downward from the most significant digit; digit 0 always shows.
  always_comb begin
    blank    = '0;
    blank[3] = Blank_lz && (shadow[15:12] == 4'h0);
    blank[2] = blank[3] && (shadow[11:8] == 4'h0);
    blank[1] = blank[2] && (shadow[7:4] == 4'h0);
    blank[0] = 1'b0;
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode scan controller with double-buffered value and
// frame-aligned load/ack handshake.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIV = 50000,
  parameter int GAP = 500
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] Value,
  input  logic        Load,
  input  logic        Blank_lz,
  output logic        Pending,
  output logic        Ack,
  output logic        Frame,
  output logic [3:0]  X,
  output logic [3:0]  Digit_en
);

  localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

  scan_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx;
  logic [15:0]      shadow, shadow_nx, hold;
  logic             pending, ack_q, frame_q;
  logic             boundary, commit;
  logic [3:0]       blank;
  logic [3:0]       en_nx, x_nx, en_q, x_q;

  seven_seg_lz_mask u_lz_mask (
    .shadow   (shadow),
    .Blank_lz (Blank_lz),
    .blank    (blank)
  );

  // Next-state, frame boundary and the values the registered outputs take next cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    boundary = 1'b0;
    case (state)
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = S_ON;
        end
      end
      S_ON: begin
        if (cnt == DIV_LAST) begin
          cnt_nx   = '0;
          state_nx = S_GAP;
          idx_nx   = idx + 2'd1;
          boundary = (idx == 2'd3);
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_GAP;
      end
    endcase
    commit    = boundary && pending;
    shadow_nx = commit ? hold : shadow;
    en_nx     = DIG_OFF;
    if ((state_nx == S_ON) && !blank[idx_nx])
      en_nx = ~(4'b0001 << idx_nx);
    // X leads the enable: the new digit's nibble is presented during its gap.
    x_nx = nibble_sel(shadow_nx, idx_nx);
  end

  // State, buffers, handshake and registered outputs.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state   <= S_GAP;
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= '0;
      hold    <= '0;
      pending <= 1'b0;
      ack_q   <= 1'b0;
      frame_q <= 1'b0;
      en_q    <= DIG_OFF;
      x_q     <= 4'h0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      shadow  <= shadow_nx;
      ack_q   <= commit;
      frame_q <= boundary;
      en_q    <= en_nx;
      x_q     <= x_nx;
      // A load on the boundary edge keeps the request alive for the next frame.
      if (Load) begin
        hold    <= Value;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  assign Pending  = pending;
  assign Ack      = ack_q;
  assign Frame    = frame_q;
  assign X        = x_q;
  assign Digit_en = en_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DIV=4, GAP=2 (24-cycle frame).
module tb_seven_seg_scan_ctrl;

  localparam int DIV = 4;
  localparam int GAP = 2;
  localparam int FRAME_LEN = 4 * (DIV + GAP);

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] Value;
  logic        Load;
  logic        Blank_lz;
  logic        Pending, Ack, Frame;
  logic [3:0]  X, Digit_en;

  int tests = 0;
  int fails = 0;

  seven_seg_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Value    (Value),
    .Load     (Load),
    .Blank_lz (Blank_lz),
    .Pending  (Pending),
    .Ack      (Ack),
    .Frame    (Frame),
    .X        (X),
    .Digit_en (Digit_en)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0]      value;
    logic             blz;
    logic [3:0][3:0]  ex;   // X per digit, MSB-first literal
    logic [3:0][3:0]  en;   // Digit_en during the digit's ON phase
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge Clock);
  endtask

  // Advance until Frame is seen; n = number of cycles advanced.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!Frame && n < 200);
    if (!Frame) begin
      tests++;
      fails++;
      $display("FAIL wait_frame: no Frame within %0d cycles", n);
    end
  endtask

  task automatic load(input logic [15:0] v);
    Value = v;
    Load  = 1'b1;
    @(negedge Clock);
    Load  = 1'b0;
  endtask

  // Called on the Frame cycle; walks one full scan and ends on the next Frame cycle.
  task automatic check_scan(input string nm, input logic [3:0][3:0] ex, input logic [3:0][3:0] en);
    for (int t = 0; t < FRAME_LEN; t++) begin
      int d;
      int off;
      logic [3:0] e;
      d   = t / (DIV + GAP);
      off = t % (DIV + GAP);
      e   = (off < GAP) ? 4'hF : en[d];
      chk({nm, "_x"}, 32'(X), 32'(ex[d]));
      chk({nm, "_en"}, 32'(Digit_en), 32'(e));
      if (t > 0) begin
        chk({nm, "_ack"}, 32'(Ack), 32'd0);
        chk({nm, "_frame"}, 32'(Frame), 32'd0);
      end
      @(negedge Clock);
    end
    chk({nm, "_frame_end"}, 32'(Frame), 32'd1);
  endtask

  initial begin
    int n;
    vecs[0] = '{value: 16'h1234, blz: 1'b0, ex: {4'h1, 4'h2, 4'h3, 4'h4}, en: {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[1] = '{value: 16'h0007, blz: 1'b1, ex: {4'h0, 4'h0, 4'h0, 4'h7}, en: {4'hF, 4'hF, 4'hF, 4'hE}};
    vecs[2] = '{value: 16'h0000, blz: 1'b1, ex: {4'h0, 4'h0, 4'h0, 4'h0}, en: {4'hF, 4'hF, 4'hF, 4'hE}};
    vecs[3] = '{value: 16'h0BEE, blz: 1'b1, ex: {4'h0, 4'hB, 4'hE, 4'hE}, en: {4'hF, 4'hB, 4'hD, 4'hE}};
    vecs[4] = '{value: 16'h00A0, blz: 1'b1, ex: {4'h0, 4'h0, 4'hA, 4'h0}, en: {4'hF, 4'hF, 4'hD, 4'hE}};
    vecs[5] = '{value: 16'h0007, blz: 1'b0, ex: {4'h0, 4'h0, 4'h0, 4'h7}, en: {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[6] = '{value: 16'hF00F, blz: 1'b1, ex: {4'hF, 4'h0, 4'h0, 4'hF}, en: {4'h7, 4'hB, 4'hD, 4'hE}};

    Resetn = 1'b0; Load = 1'b0; Value = 16'h0; Blank_lz = 1'b0;
    step(2);
    chk("rst_en", 32'(Digit_en), 32'hF);
    chk("rst_x", 32'(X), 32'h0);
    chk("rst_pending", 32'(Pending), 32'd0);
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_frame", 32'(Frame), 32'd0);

    // Release: first two cycles dark, then digit 0 lit for four.
    Resetn = 1'b1;
    for (int t = 0; t < 6; t++) begin
      chk("rel_en", 32'(Digit_en), (t < GAP) ? 32'hF : 32'hE);
      chk("rel_x", 32'(X), 32'h0);
      if (t < 5) @(negedge Clock);
    end
    wait_frame(n);
    chk("first_frame_at", 32'(n), 32'(FRAME_LEN - 5));
    chk("first_frame_ack", 32'(Ack), 32'd0);
    chk("first_frame_pending", 32'(Pending), 32'd0);
    wait_frame(n);
    chk("frame_period", 32'(n), 32'(FRAME_LEN));

    // Table: load each value mid-frame, expect one Ack, then check the whole scan.
    for (int i = 0; i < 7; i++) begin
      Blank_lz = vecs[i].blz;
      step(3);
      load(vecs[i].value);
      chk("vec_pending", 32'(Pending), 32'd1);
      wait_frame(n);
      chk("vec_frame_at", 32'(n), 32'(FRAME_LEN - 4));
      chk("vec_ack", 32'(Ack), 32'd1);
      chk("vec_pending_clr", 32'(Pending), 32'd0);
      check_scan($sformatf("vec%0d", i), vecs[i].ex, vecs[i].en);
      chk("vec_no_ack", 32'(Ack), 32'd0);
    end

    // Two loads in one frame: last wins, single Ack.
    Blank_lz = 1'b0;
    step(2);
    load(16'hAAAA);
    step(7);
    load(16'h5555);
    chk("dbl_pending", 32'(Pending), 32'd1);
    wait_frame(n);
    chk("dbl_frame_at", 32'(n), 32'(FRAME_LEN - 11));
    chk("dbl_ack", 32'(Ack), 32'd1);
    check_scan("dbl", {4'h5, 4'h5, 4'h5, 4'h5}, {4'h7, 4'hB, 4'hD, 4'hE});
    chk("dbl_no_second_ack", 32'(Ack), 32'd0);

    // Load on the exact boundary cycle while another value is pending.
    step(2);
    load(16'h1111);
    step(20);
    Value = 16'h0BEE;
    Load  = 1'b1;
    @(negedge Clock);
    Load  = 1'b0;
    chk("bnd_frame", 32'(Frame), 32'd1);
    chk("bnd_ack1", 32'(Ack), 32'd1);
    chk("bnd_pending_kept", 32'(Pending), 32'd1);
    chk("bnd_x_old", 32'(X), 32'h1);
    wait_frame(n);
    chk("bnd_frame2_at", 32'(n), 32'(FRAME_LEN));
    chk("bnd_ack2", 32'(Ack), 32'd1);
    chk("bnd_pending_clr", 32'(Pending), 32'd0);
    chk("bnd_x_new", 32'(X), 32'hE);

    // Blank_lz toggled while digit 3 is lit takes effect on the next edge.
    step(2);
    load(16'h0007);
    wait_frame(n);
    chk("tog_ack", 32'(Ack), 32'd1);
    step(20);
    chk("tog_on", 32'(Digit_en), 32'h7);
    Blank_lz = 1'b1;
    @(negedge Clock);
    chk("tog_blank", 32'(Digit_en), 32'hF);
    Blank_lz = 1'b0;
    @(negedge Clock);
    chk("tog_unblank", 32'(Digit_en), 32'h7);
    wait_frame(n);
    chk("tog_frame_at", 32'(n), 32'd2);

    // Reset during digit 2 ON with a pending load: the load is lost.
    step(1);
    load(16'h9999);
    chk("mid_pending", 32'(Pending), 32'd1);
    step(13);
    chk("mid_d2_on", 32'(Digit_en), 32'hB);
    Resetn = 1'b0;
    @(negedge Clock);
    chk("mid_rst_en", 32'(Digit_en), 32'hF);
    chk("mid_rst_x", 32'(X), 32'h0);
    chk("mid_rst_pending", 32'(Pending), 32'd0);
    chk("mid_rst_ack", 32'(Ack), 32'd0);
    Resetn = 1'b1;
    wait_frame(n);
    chk("mid_frame_at", 32'(n), 32'(FRAME_LEN));
    chk("mid_no_ack", 32'(Ack), 32'd0);
    check_scan("mid_scan", {4'h0, 4'h0, 4'h0, 4'h0}, {4'h7, 4'hB, 4'hD, 4'hE});
    chk("mid_no_ack_end", 32'(Ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexes one 4-bit-to-7-segment decoder across four common-anode digits of a display.
- Holds a double-buffered 16-bit display value and presents one nibble at a time on X.
- Drives active-low digit enables with an anti-ghosting gap between digits.
- Accepts new values through a load/ack handshake that commits only at frame boundaries; optionally blanks leading zeros.

Parameters:
- DIV, 50000, clock cycles each digit is lit (ON phase); legal range is 1 or more.
- GAP, 500, clock cycles all digits are dark between digits (GAP phase); legal range is 1 or more.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Resetn  input  1  synchronous, active-low reset.
- Value  input  16  new display value; [15:12] is digit 3 (most significant), [3:0] is digit 0.
- Load  input  1  request to capture Value; single-cycle or level, sampled every cycle.
- Blank_lz  input  1  1 enables leading-zero blanking.
- Pending  output  1  a captured value is waiting for the frame boundary.
- Ack  output  1  one-cycle pulse when the pending value is committed to the shadow register.
- Frame  output  1  one-cycle pulse at the end of each full 4-digit scan.
- X  output  4  nibble for the downstream decoder inputs; X[3] maps to decoder input X3.
- Digit_en  output  4  active-low digit enables; bit i is digit i.

Behaviour:
- Reset, applied on a Clock edge while Resetn=0:
  - Digit_en=4'b1111; X=0; Pending=0; Ack=0; Frame=0.
  - shadow=0; hold=0; idx=0; state=S_GAP; cnt=0.
  - Any pending load is discarded. Reset mid-scan or mid-handshake takes effect on that same edge.
- Scan FSM, with states S_GAP and S_ON:
  - S_GAP: Digit_en=4'b1111 for exactly GAP cycles. X=shadow nibble[idx] throughout, so the decoder settles before its digit is lit. At cnt=GAP-1: cnt<=0, state<=S_ON.
  - S_ON: Digit_en[idx]=0 and the other bits are 1, for exactly DIV cycles, unless digit idx is blanked (then all bits stay 1). At cnt=DIV-1: cnt<=0, state<=S_GAP, idx<=idx+1, wrapping 3->0.
  - All outputs are registered. Frame period is exactly 4*(DIV+GAP) cycles.
- Frame boundary is the last S_ON cycle with idx=3:
  - Frame=1 on the following cycle.
  - If Pending=1 on the boundary cycle: shadow<=hold, Pending<=0, and Ack=1 on the following cycle, aligned with Frame.
  - The new shadow is first visible on X in the S_GAP of digit 0.
- Load handling:
  - Load=1: hold<=Value and Pending<=1.
  - Load while already pending: the latest Value wins; there is only one Ack, at the next boundary.
  - Load on the boundary cycle: the commit uses the previous hold; the new Value is captured; Pending stays 1 and commits next frame.
- Leading-zero blanking:
  - Digit i in 1..3 is blanked when Blank_lz=1 and shadow nibbles 3 down to i are all zero.
  - Digit 0 is never blanked, so a value of 0 shows a single lit digit.
  - The mask is combinational from shadow and Blank_lz and is sampled every S_ON cycle. Toggling Blank_lz mid-digit takes effect on the next edge.
- Counter width: clog2(max(DIV,GAP)). The counter never exceeds its terminal count.
- X is not blanked; blanking is done solely through Digit_en.

Decomposition:
- seven_seg_pkg holds:
  - scan_state_t enum {S_GAP, S_ON}.
  - NDIG=4.
  - DIG_OFF=4'b1111.
  - Function nibble_sel(value16, idx).
- Sub-module seven_seg_lz_mask: combinational; inputs shadow[15:0] and Blank_lz; output blank[3:0]; blank[0] is tied to 0.
- The 7-segment decoder is instantiated beside this block, not inside it.

Test Plan:
- Reset release, DIV=4, GAP=2 -> X=0 and Digit_en=1111 for 2 cycles, then Digit_en=1110 for 4 cycles. Frame pulses every 24 cycles; Pending=0 and Ack=0.
- Load=1 for one cycle with Value=16'h1234 mid-frame -> Pending=1 until the boundary; Ack and Frame pulse together. The next scan shows X=4,3,2,1 with Digit_en=1110,1101,1011,0111.
- Loads 16'hAAAA then 16'h5555 in the same frame -> exactly one Ack; the displayed value is 5555.
- Load with 16'h0BEE on the exact boundary cycle while Pending=1 with 16'h1111 -> 1111 is committed with Ack; Pending stays 1; 0BEE commits with a second Ack one frame later.
- Blank_lz=1 with shadow=16'h0007 -> only digit 0 is lit (Digit_en=1110 in its ON phase, 1111 elsewhere). With shadow=16'h0000, digit 0 is still lit and X=0.
- Resetn=0 for one cycle during S_ON of digit 2 with Pending=1 -> next cycle Digit_en=1111, X=0, Pending=0, shadow=0; no Ack is ever produced for the lost load.
